timer_cnt_unit: RTL and testbench

- Counting stage of the 8-bit timer, directly upstream of the overflow/underflow comparator.
- Generates the internal prescaled clock tick (pclk/2, /4, /8, /16) selected by the control register.
- Owns the TCNT register: parallel load from TDR, up/down count with natural wrap.
- Emits a one-cycle count_enable pulse aligned so the downstream comparator sees {previous TCNT, new TCNT} in the same cycle as the pulse.

---
 rtl/timer_cnt_unit.sv | 45 ++++
 tb/tb_timer_cnt_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/timer_cnt_unit.sv
// Counting stage of the 8-bit timer: prescaler, tick selection, and TCNT load/up/down.
// count_enable marks the cycle in which TCNT first shows a counted (not loaded) value.
module timer_cnt_unit #(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic [DW-1:0] TDR,
  input  logic          load,
  input  logic          timer_en,
  input  logic          count_up_down,
  input  logic [1:0]    cks,
  output logic [DW-1:0] TCNT,
  output logic          count_enable
);

  logic [PW-1:0] div_cnt;
  logic          sel, sel_d, tick;
  logic [1:0]    cks_d;

  // Rising edge of the selected divider bit; masked for the cycle in which cks changes
  assign sel  = div_cnt[cks];
  assign tick = timer_en & ~load & sel & ~sel_d & (cks == cks_d);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      div_cnt      <= '0;
      sel_d        <= 1'b0;
      cks_d        <= 2'd0;
      TCNT         <= '0;
      count_enable <= 1'b0;
    end else begin
      div_cnt      <= timer_en ? div_cnt + 1'b1 : '0;
      sel_d        <= sel;
      cks_d        <= cks;
      count_enable <= tick & ~load;
      if (load)
        TCNT <= TDR;
      else if (tick)
        TCNT <= count_up_down ? TCNT - 1'b1 : TCNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_cnt_unit.sv
// Directed bench for timer_cnt_unit; expected TCNT/count_enable traces are hand-computed.
module tb_timer_cnt_unit;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic [7:0] TDR = 8'h00;
  logic       load = 1'b0;
  logic       timer_en = 1'b0;
  logic       count_up_down = 1'b0;
  logic [1:0] cks = 2'd0;
  logic [7:0] TCNT;
  logic       count_enable;

  int n_chk = 0;
  int n_err = 0;

  timer_cnt_unit #(.DW(8), .PW(4)) dut (
    .pclk(pclk), .preset_n(preset_n), .TDR(TDR), .load(load), .timer_en(timer_en),
    .count_up_down(count_up_down), .cks(cks), .TCNT(TCNT), .count_enable(count_enable)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and check the outputs
  task automatic cyc(input string tag, input logic [7:0] exp_t, input logic exp_ce);
    @(negedge pclk);
    chk({tag, "_tcnt"}, {24'd0, TCNT}, {24'd0, exp_t});
    chk({tag, "_ce"}, {31'd0, count_enable}, {31'd0, exp_ce});
  endtask

  // Load a start value with the timer stopped (prescaler cleared), then enable
  task automatic setup(input logic [7:0] v, input logic [1:0] c, input logic dn);
    timer_en = 1'b0; load = 1'b1; TDR = v; cks = c; count_up_down = dn;
    @(negedge pclk);
    load = 1'b0; timer_en = 1'b1;
  endtask

  initial begin
    // reset state
    @(negedge pclk);
    chk("rst_tcnt", {24'd0, TCNT}, 32'h0);
    chk("rst_ce", {31'd0, count_enable}, 32'h0);
    chk("rst_div", {28'd0, dut.div_cnt}, 32'h0);
    preset_n = 1'b1;

    // cks=0 up from 00: first step one edge after enable, then every 2
    setup(8'h00, 2'd0, 1'b0);
    cyc("t1_n0", 8'h00, 1'b0);
    cyc("t1_s1", 8'h01, 1'b1);
    cyc("t1_h1", 8'h01, 1'b0);
    cyc("t1_s2", 8'h02, 1'b1);
    cyc("t1_h2", 8'h02, 1'b0);
    cyc("t1_s3", 8'h03, 1'b1);

    // cks=3: first step at N+8, then every 16
    setup(8'h00, 2'd3, 1'b0);
    for (int i = 0; i < 8; i++) cyc("t2_wait", 8'h00, 1'b0);
    cyc("t2_s1", 8'h01, 1'b1);
    for (int i = 0; i < 15; i++) cyc("t2_hold", 8'h01, 1'b0);
    cyc("t2_s2", 8'h02, 1'b1);

    // Up-count wrap FF -> 00 signalled with count_enable
    setup(8'hFD, 2'd0, 1'b0);
    cyc("t3_n0", 8'hFD, 1'b0);
    cyc("t3_fe", 8'hFE, 1'b1);
    cyc("t3_h0", 8'hFE, 1'b0);
    cyc("t3_ff", 8'hFF, 1'b1);
    cyc("t3_h1", 8'hFF, 1'b0);
    cyc("t3_00", 8'h00, 1'b1);
    cyc("t3_h2", 8'h00, 1'b0);
    cyc("t3_01", 8'h01, 1'b1);

    // Down-count wrap 00 -> FF, cks=1 (every 4)
    setup(8'h01, 2'd1, 1'b1);
    cyc("t4_n0", 8'h01, 1'b0);
    cyc("t4_n1", 8'h01, 1'b0);
    cyc("t4_00", 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc("t4_h0", 8'h00, 1'b0);
    cyc("t4_ff", 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cyc("t4_h1", 8'hFF, 1'b0);
    cyc("t4_fe", 8'hFE, 1'b1);

    // Load on a tick edge wins; then cks 0 -> 2 on a would-be tick cycle
    setup(8'h10, 2'd0, 1'b0);
    cyc("t5_n0", 8'h10, 1'b0);
    cyc("t5_s1", 8'h11, 1'b1);
    cyc("t5_h1", 8'h11, 1'b0);
    load = 1'b1; TDR = 8'h55;
    cyc("t5_ld", 8'h55, 1'b0);
    load = 1'b0;
    cyc("t5_ph", 8'h55, 1'b0);
    cyc("t5_56", 8'h56, 1'b1);
    cyc("t5_h2", 8'h56, 1'b0);
    cyc("t5_57", 8'h57, 1'b1);
    cyc("t5_h3", 8'h57, 1'b0);
    cyc("t5_58", 8'h58, 1'b1);
    cyc("t5_h4", 8'h58, 1'b0);
    cyc("t5_59", 8'h59, 1'b1);
    cyc("t5_h5", 8'h59, 1'b0);
    cks = 2'd2;
    for (int i = 0; i < 7; i++) cyc("t5_mask", 8'h59, 1'b0);
    cyc("t5_5a", 8'h5A, 1'b1);
    for (int i = 0; i < 7; i++) cyc("t5_h6", 8'h5A, 1'b0);
    cyc("t5_5b", 8'h5B, 1'b1);

    // Disable freezes TCNT and clears the prescaler; re-enable restarts timing
    timer_en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("t6_frz", 8'h5B, 1'b0);
    chk("t6_div", {28'd0, dut.div_cnt}, 32'h0);
    timer_en = 1'b1;
    for (int i = 0; i < 4; i++) cyc("t6_re", 8'h5B, 1'b0);
    cyc("t6_5c", 8'h5C, 1'b1);

    // Asynchronous reset mid-count, between clock edges
    #2 preset_n = 1'b0;
    #1;
    chk("t7_rst_tcnt", {24'd0, TCNT}, 32'h0);
    chk("t7_rst_ce", {31'd0, count_enable}, 32'h0);
    timer_en = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    cyc("t7_post", 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
